// File: rtl/neuron_pkg.sv
// Shared widths, neuron word types and the bank state encoding for the neuron accumulator slice.
package neuron_pkg;

  localparam int NR_WIDTH     = 56;
  localparam int NR_I_WIDTH   = 16;
  localparam int SR_SYN_WIDTH = 4;

  typedef logic [NR_WIDTH-1:0]          neuron_word_t;
  typedef logic signed [NR_I_WIDTH-1:0] neuron_i_t;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } accum_state_t;

endpackage

// File: rtl/neuron_i_adder.sv
// Combinational I-field update: sign-extends a synaptic weight and adds it to the current I.
// With NEURON_ACCUM_SAT_EN the sum clamps to the signed I range and reports the clamp on sat.
module neuron_i_adder #(
  parameter int I_WIDTH = 16,
  parameter int W_WIDTH = 4
) (
  input  logic [I_WIDTH-1:0] i_old,
  input  logic [W_WIDTH-1:0] w,
`ifdef NEURON_ACCUM_SAT_EN
  output logic               sat,
`endif
  output logic [I_WIDTH-1:0] i_new
);

`ifdef NEURON_ACCUM_SAT_EN
  logic [I_WIDTH:0] sum;

  // One guard bit: overflow shows up as disagreement between the top two sum bits.
  always_comb begin
    sum   = {i_old[I_WIDTH-1], i_old} + {{(I_WIDTH+1-W_WIDTH){w[W_WIDTH-1]}}, w};
    sat   = sum[I_WIDTH] ^ sum[I_WIDTH-1];
    i_new = sum[I_WIDTH-1:0];
    if (sat) begin
      i_new = sum[I_WIDTH] ? {1'b1, {(I_WIDTH-1){1'b0}}} : {1'b0, {(I_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    i_new = i_old + {{(I_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w};
  end
`endif

endmodule

// File: rtl/neuron_accum_bank.sv
// Bank of neuron state words: accumulates synaptic events into each word's I field and drains
// the bank in index order. Optional saturating arithmetic under NEURON_ACCUM_SAT_EN.
module neuron_accum_bank
  import neuron_pkg::*;
#(
  parameter int NR_WIDTH       = neuron_pkg::NR_WIDTH,
  parameter int NR_I_WIDTH     = neuron_pkg::NR_I_WIDTH,
  parameter int SR_SYN_WIDTH   = neuron_pkg::SR_SYN_WIDTH,
  parameter int NUM_NEURONS    = 16,
  parameter int IDX_WIDTH      = $clog2(NUM_NEURONS),
  parameter int CLEAR_ON_DRAIN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  input  logic [IDX_WIDTH-1:0]    load_idx,
  input  logic [NR_WIDTH-1:0]     load_data,
  input  logic                    syn_valid,
  output logic                    syn_ready,
  input  logic [IDX_WIDTH-1:0]    syn_idx,
  input  logic [SR_SYN_WIDTH-1:0] syn_w,
  input  logic                    drain_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_WIDTH-1:0]    out_idx,
  output logic [NR_WIDTH-1:0]     out_data,
  output logic                    drain_done,
`ifdef NEURON_ACCUM_SAT_EN
  output logic                    sat_flag,
`endif
  output logic                    busy
);

  localparam logic [IDX_WIDTH:0]   DEPTH    = (IDX_WIDTH+1)'(NUM_NEURONS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  accum_state_t state, state_nxt;

  logic [NR_WIDTH-1:0]   bank [NUM_NEURONS];
  logic [IDX_WIDTH-1:0]  cnt;
  logic                  syn_in_range, load_in_range;
  logic                  syn_hit, load_hit, out_fire;
  logic [NR_I_WIDTH-1:0] i_cur, i_sum;
`ifdef NEURON_ACCUM_SAT_EN
  logic                  sat_now;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    syn_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ACCUM: begin
        syn_ready = !load_valid;
        if (drain_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && (cnt == LAST_IDX)) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    syn_in_range  = ({1'b0, syn_idx} < DEPTH);
    load_in_range = ({1'b0, load_idx} < DEPTH);
    syn_hit       = syn_valid && syn_ready && syn_in_range;
    load_hit      = (state == ACCUM) && load_valid && load_in_range;
    out_fire      = out_valid && out_ready;
    i_cur         = syn_in_range ? bank[syn_idx][NR_I_WIDTH-1:0] : '0;
    out_idx       = cnt;
    out_data      = bank[cnt];
  end

  neuron_i_adder #(
    .I_WIDTH(NR_I_WIDTH),
    .W_WIDTH(SR_SYN_WIDTH)
  ) u_adder (
    .i_old(i_cur),
    .w    (syn_w),
`ifdef NEURON_ACCUM_SAT_EN
    .sat  (sat_now),
`endif
    .i_new(i_sum)
  );

  // Loads and events are only possible in ACCUM, clears only in DRAIN, so the writes never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_NEURONS; k++) bank[k] <= '0;
    end else begin
      if (load_hit) begin
        bank[load_idx] <= load_data;
      end else if (syn_hit) begin
        bank[syn_idx][NR_I_WIDTH-1:0] <= i_sum;
      end
      if (out_fire && (CLEAR_ON_DRAIN != 0)) begin
        bank[cnt][NR_I_WIDTH-1:0] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      drain_done <= 1'b0;
`ifdef NEURON_ACCUM_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      drain_done <= out_fire && (cnt == LAST_IDX);
      if (out_fire) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
`ifdef NEURON_ACCUM_SAT_EN
      sat_flag   <= syn_hit && sat_now;
`endif
    end
  end

endmodule

// File: tb/tb_neuron_accum_bank.sv
// Directed self-checking bench for neuron_accum_bank: accumulate, load priority, wrap/saturate,
// stalled drain with clear, and reset in the middle of a drain.
module tb_neuron_accum_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [3:0]  load_idx;
  logic [55:0] load_data;
  logic        syn_valid;
  logic        syn_ready;
  logic [3:0]  syn_idx;
  logic [3:0]  syn_w;
  logic        drain_req;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic [55:0] out_data;
  logic        drain_done;
  logic        busy;
`ifdef NEURON_ACCUM_SAT_EN
  logic        sat_flag;
`endif

  int vectors = 0;
  int fails   = 0;

  logic [55:0] exp1 [16];
  logic [55:0] exp2 [16];

  always #5 clk = ~clk;

  neuron_accum_bank #(
    .NR_WIDTH      (56),
    .NR_I_WIDTH    (16),
    .SR_SYN_WIDTH  (4),
    .NUM_NEURONS   (16),
    .IDX_WIDTH     (4),
    .CLEAR_ON_DRAIN(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_idx  (load_idx),
    .load_data (load_data),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn_idx   (syn_idx),
    .syn_w     (syn_w),
    .drain_req (drain_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .drain_done(drain_done),
`ifdef NEURON_ACCUM_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_idx = '0; load_data = '0;
    syn_valid = 1'b0; syn_idx = '0; syn_w = '0; drain_req = 1'b0; out_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      exp1[i] = '0;
      exp2[i] = '0;
    end
    exp1[2] = 56'h12_3456_7800_0101;
    exp1[3] = 56'hAB_CD00_0000_000D;
`ifdef NEURON_ACCUM_SAT_EN
    exp1[4] = 56'h00_0000_0011_7FFF;
`else
    exp1[4] = 56'h00_0000_0011_8000;
`endif
`ifdef NEURON_ACCUM_SAT_EN
    exp1[5] = 56'h00_0000_0022_8000;
`else
    exp1[5] = 56'h00_0000_0022_7FF8;
`endif
    exp1[7] = 56'h00_0000_0000_0003;
    exp2[2] = 56'h12_3456_7800_0000;
    exp2[3] = 56'hAB_CD00_0000_0000;
    exp2[4] = 56'h00_0000_0011_0000;
    exp2[5] = 56'h00_0000_0022_0000;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_syn_ready", syn_ready, 1);
    rst_n = 1'b1;

    // word 3 load, then three back-to-back events: 5 + 2 - 1 + 7 = 13
    @(negedge clk);
    load_valid = 1'b1; load_idx = 4'd3; load_data = 56'hAB_CD00_0000_0005;
    @(negedge clk);
    load_valid = 1'b0; syn_valid = 1'b1; syn_idx = 4'd3; syn_w = 4'h2;
    @(negedge clk);
    syn_w = 4'hF;
    @(negedge clk);
    syn_w = 4'h7;
    #1 chk("accum_syn_ready", syn_ready, 1);
    @(negedge clk);
    syn_valid = 1'b0;

    // load and event collide on word 2: load wins, event lands next cycle
    load_valid = 1'b1; load_idx = 4'd2; load_data = 56'h12_3456_7800_0100;
    syn_valid = 1'b1; syn_idx = 4'd2; syn_w = 4'h1;
    #1 chk("load_blocks_syn", syn_ready, 0);
    @(negedge clk);
    load_valid = 1'b0;
    #1 chk("syn_after_load", syn_ready, 1);
    @(negedge clk);
    syn_valid = 1'b0;

    // overflow corner cases on words 4 and 5
    load_valid = 1'b1; load_idx = 4'd4; load_data = 56'h00_0000_0011_7FFF;
    @(negedge clk);
    load_idx = 4'd5; load_data = 56'h00_0000_0022_8000;
    @(negedge clk);
    load_valid = 1'b0; syn_valid = 1'b1; syn_idx = 4'd4; syn_w = 4'h1;
    @(negedge clk);
`ifdef NEURON_ACCUM_SAT_EN
    chk("sat_flag_pos", sat_flag, 1);
`endif
    syn_idx = 4'd5; syn_w = 4'h8;
    @(negedge clk);
`ifdef NEURON_ACCUM_SAT_EN
    chk("sat_flag_neg", sat_flag, 1);
`endif

    // event on word 7 in the same cycle as drain_req
    syn_idx = 4'd7; syn_w = 4'h3; drain_req = 1'b1;
    #1 chk("drain_req_syn_ready", syn_ready, 1);
    @(negedge clk);
`ifdef NEURON_ACCUM_SAT_EN
    chk("sat_flag_idle", sat_flag, 0);
`endif
    drain_req = 1'b0; syn_idx = 4'd1; syn_w = 4'h5;
    chk("drain_busy", busy, 1);
    chk("drain_syn_ready", syn_ready, 0);

    // drain with one stall cycle per word
    for (int i = 0; i < 16; i++) begin
      chk("d1_valid", out_valid, 1);
      chk("d1_idx", out_idx, i);
      chk("d1_data", out_data, exp1[i]);
      chk("d1_syn_ready", syn_ready, 0);
      if (i == 2) syn_valid = 1'b0;
      if (i == 4) begin
        drain_req = 1'b1; load_valid = 1'b1; load_idx = 4'd0; load_data = 56'hFF_FFFF_FFFF_FFFF;
      end
      if (i == 6) begin
        drain_req = 1'b0; load_valid = 1'b0;
      end
      out_ready = 1'b0;
      @(negedge clk);
      chk("d1_stall_idx", out_idx, i);
      chk("d1_stall_data", out_data, exp1[i]);
      chk("d1_no_done", drain_done, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("d1_done_pulse", drain_done, 1);
    chk("d1_end_busy", busy, 0);
    chk("d1_end_valid", out_valid, 0);
    @(negedge clk);
    chk("d1_done_clear", drain_done, 0);
    chk("d1_idle_ready", syn_ready, 1);

    // second drain: I cleared, upper fields intact; reset after word 5
    drain_req = 1'b1;
    @(negedge clk);
    drain_req = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("d2_idx", out_idx, i);
      chk("d2_data", out_data, exp2[i]);
      @(negedge clk);
    end
    chk("d2_idx6", out_idx, 6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", drain_done, 0);
    chk("mid_rst_ready", syn_ready, 1);
    chk("mid_rst_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // third drain: every word back to zero
    drain_req = 1'b1;
    @(negedge clk);
    drain_req = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("d3_idx", out_idx, i);
      chk("d3_data", out_data, 0);
      @(negedge clk);
    end
    chk("d3_done_pulse", drain_done, 1);
    chk("d3_end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
